// File: rtl/bus_arbiter_if.sv
// Request/grant and bus-monitor signals shared by the arbiter and the nodes.
interface bus_arbiter_if #(
    parameter int unsigned NODES = 16
);
    logic [NODES-1:0] req;
    logic             bus;
    logic [NODES-1:0] mod;
    logic [3:0]       owner;
    logic             busy;
    logic             done;
    logic             timeout_err;

    // Arbiter side: watches requests and the bus, drives the sender select.
    modport master (
        input  req,
        input  bus,
        output mod,
        output owner,
        output busy,
        output done,
        output timeout_err
    );

    // Node side: raises requests and reflects the shared wire.
    modport slave (
        output req,
        output bus,
        input  mod,
        input  owner,
        input  busy,
        input  done,
        input  timeout_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner of the single-wire node bus: grants one sender at a time,
// follows the packet and ack on the bus, and releases on completion or timeout.
module bus_arbiter #(
    parameter int unsigned NODES    = 16,
    parameter int unsigned PKT_BITS = 80,
    parameter int unsigned ACK_BITS = 2,
    parameter int unsigned TIMEOUT  = 255
) (
    input logic           clock,
    input logic           reset,
    bus_arbiter_if.master arb_if
);
    localparam int unsigned IDX_W = 4;
    localparam int unsigned BIT_W = 7;
    localparam int unsigned ACK_W = 2;
    localparam int unsigned TMO_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_RECV,
        S_WAIT_ACK,
        S_RELEASE
    } state_t;

    state_t             state_q;
    logic [NODES-1:0]   mod_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   ptr_q;
    logic               busy_q;
    logic               done_q;
    logic               tmo_err_q;
    logic [BIT_W-1:0]   bit_cnt_q;
    logic [ACK_W-1:0]   ack_cnt_q;
    logic [TMO_W-1:0]   tmo_cnt_q;

    logic [IDX_W-1:0]   win_c;
    logic               any_c;
    logic               bus_lo_c;
    logic               bus_hi_c;
    logic [TMO_W-1:0]   tmo_inc_c;
    logic [ACK_W-1:0]   ack_inc_c;
    logic [IDX_W-1:0]   ptr_nxt_c;

    // An undriven or unknown bus level is treated as neither low nor high.
    assign bus_lo_c  = (arb_if.bus == 1'b0);
    assign bus_hi_c  = (arb_if.bus == 1'b1);

    // Timeout counter saturates instead of wrapping.
    assign tmo_inc_c = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
    assign ack_inc_c = ack_cnt_q + ACK_W'(1);
    assign ptr_nxt_c = (owner_q == IDX_W'(NODES - 1)) ? '0 : owner_q + IDX_W'(1);

    // Round-robin search: first request at ptr, ptr+1, ... wrapping past NODES-1.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        win_c = '0;
        any_c = 1'b0;
        for (int unsigned i = 0; i < NODES; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NODES) begin
                idx = idx - NODES;
            end
            if (!any_c && arb_if.req[IDX_W'(idx)]) begin
                any_c = 1'b1;
                win_c = IDX_W'(idx);
            end
        end
    end

    // Transaction tracker; every output is a register updated here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mod_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tmo_err_q <= 1'b0;
            bit_cnt_q <= '0;
            ack_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            done_q    <= 1'b0;
            tmo_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_c) begin
                        mod_q     <= NODES'(1) << win_c;
                        owner_q   <= win_c;
                        tmo_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= S_GRANT;
                    end else begin
                        mod_q     <= '0;
                    end
                end
                S_GRANT: begin
                    if (bus_lo_c) begin
                        // The start bit itself is packet bit 0.
                        bit_cnt_q <= BIT_W'(1);
                        state_q   <= S_RECV;
                    end else begin
                        tmo_cnt_q <= tmo_inc_c;
                        if (tmo_inc_c == TMO_W'(TIMEOUT)) begin
                            tmo_err_q <= 1'b1;
                            state_q   <= S_RELEASE;
                        end
                    end
                end
                S_RECV: begin
                    bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(PKT_BITS - 1)) begin
                        ack_cnt_q <= '0;
                        tmo_cnt_q <= '0;
                        state_q   <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    ack_cnt_q <= bus_hi_c ? ack_inc_c : '0;
                    tmo_cnt_q <= tmo_inc_c;
                    if (bus_hi_c && (ack_inc_c == ACK_W'(ACK_BITS))) begin
                        done_q    <= 1'b1;
                        state_q   <= S_RELEASE;
                    end else if (tmo_inc_c == TMO_W'(TIMEOUT)) begin
                        tmo_err_q <= 1'b1;
                        state_q   <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    // One idle cycle with mod==0 separates consecutive senders.
                    mod_q   <= '0;
                    ptr_q   <= ptr_nxt_c;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    mod_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign arb_if.mod         = mod_q;
    assign arb_if.owner       = owner_q;
    assign arb_if.busy        = busy_q;
    assign arb_if.done        = done_q;
    assign arb_if.timeout_err = tmo_err_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed transactions push expected grant/done/
// timeout/release events; a negedge monitor pops and compares them.
module tb_bus_arbiter;
    localparam int unsigned NODES   = 16;
    localparam int unsigned TIMEOUT = 255;

    localparam int K_GRANT = 0;
    localparam int K_DONE  = 1;
    localparam int K_TMO   = 2;
    localparam int K_REL   = 3;

    localparam int M_ACK    = 0;
    localparam int M_NOACK  = 1;
    localparam int M_NOSTRT = 2;
    localparam int M_RESET  = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [15:0] mod;
        int          owner;
        int          ptr;
    } want_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    bus_arbiter_if #(.NODES(NODES)) ifc ();

    bus_arbiter #(
        .NODES   (NODES),
        .PKT_BITS(80),
        .ACK_BITS(2),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .arb_if(ifc)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    want_t       sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] prev_mod = '0;

    function automatic void chk(string name, int act, int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, want, cyc);
        end
    endfunction

    function automatic void push(int kind, int c, logic [15:0] m, int own, int p);
        want_t w;
        w.kind  = kind;
        w.cyc   = c;
        w.mod   = m;
        w.owner = own;
        w.ptr   = p;
        sb.push_back(w);
    endfunction

    function automatic void ev(int kind);
        want_t w;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d expected none at cycle %0d", kind, cyc);
        end else begin
            w = sb.pop_front();
            chk("ev_kind", kind, w.kind);
            chk("ev_cycle", cyc, w.cyc);
            chk("ev_mod", int'(ifc.mod), int'(w.mod));
            chk("ev_owner", int'(ifc.owner), w.owner);
            if (kind == K_GRANT) chk("grant_busy", int'(ifc.busy), 1);
            if (kind == K_REL) begin
                chk("rel_busy", int'(ifc.busy), 0);
                chk("rel_ptr", int'(dut.ptr_q), w.ptr);
                chk("rel_done_low", int'(ifc.done), 0);
                chk("rel_tmo_low", int'(ifc.timeout_err), 0);
            end
        end
    endfunction

    // Monitor: invariants every cycle plus event detection into the scoreboard.
    always @(negedge clock) begin
        logic [15:0] m;
        m = ifc.mod;
        chk("mod_onehot0", int'($onehot0(m)), 1);
        chk("done_tmo_excl", int'(ifc.done & ifc.timeout_err), 0);
        if (prev_mod != '0 && m != '0) chk("mod_hold", int'(m), int'(prev_mod));
        if (prev_mod == '0 && m != '0) ev(K_GRANT);
        if (ifc.done)                  ev(K_DONE);
        if (ifc.timeout_err)           ev(K_TMO);
        if (prev_mod != '0 && m == '0) ev(K_REL);
        prev_mod = m;
    end

    function automatic logic pkt_bit(int i);
        return (i % 3) != 0;
    endfunction

    task automatic drive(input logic b);
        ifc.bus = b;
        @(negedge clock);
    endtask

    // One transaction starting at a negedge with the arbiter idle; returns at
    // the first negedge after it is idle again.
    task automatic txn(input logic [15:0] r, input logic [15:0] mid, input int node, input int mode);
        int          c;
        int          s;
        int          nx;
        logic [15:0] oh;
        oh      = 16'(1) << node;
        nx      = (node + 1) % 16;
        ifc.req = r;
        ifc.bus = 1'b1;
        c       = cyc;
        push(K_GRANT, c + 1, oh, node, 0);
        @(negedge clock);
        ifc.req = mid;
        s       = cyc;
        case (mode)
            M_ACK: begin
                push(K_DONE, s + 83, oh, node, 0);
                push(K_REL, s + 84, 16'h0, node, nx);
                drive(1'b0);
                for (int i = 1; i < 80; i++) drive(pkt_bit(i));
                drive(1'b0);
                drive(1'b1);
                drive(1'b1);
                ifc.bus = 1'b1;
                @(negedge clock);
            end
            M_NOACK: begin
                push(K_TMO, s + 80 + 255, oh, node, 0);
                push(K_REL, s + 80 + 256, 16'h0, node, nx);
                drive(1'b0);
                for (int i = 1; i < 80; i++) drive(pkt_bit(i));
                repeat (255) drive(1'b0);
                ifc.bus = 1'b1;
                @(negedge clock);
            end
            M_NOSTRT: begin
                push(K_TMO, s + 255, oh, node, 0);
                push(K_REL, s + 256, 16'h0, node, nx);
                repeat (255) drive(1'b1);
                @(negedge clock);
            end
            default: begin
                push(K_REL, s + 41, 16'h0, 0, 0);
                drive(1'b0);
                for (int i = 1; i < 40; i++) drive(pkt_bit(i));
                reset   = 1'b1;
                ifc.bus = pkt_bit(40);
                @(negedge clock);
                reset   = 1'b0;
                ifc.bus = 1'b1;
            end
        endcase
    endtask

    // Safety net in case the DUT stops responding.
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence.
    initial begin
        ifc.req = '0;
        ifc.bus = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_mod", int'(ifc.mod), 0);
        chk("rst_owner", int'(ifc.owner), 0);
        chk("rst_busy", int'(ifc.busy), 0);
        chk("rst_done", int'(ifc.done), 0);
        chk("rst_tmo", int'(ifc.timeout_err), 0);
        chk("rst_ptr", int'(dut.ptr_q), 0);
        reset = 1'b0;
        @(negedge clock);

        // Simultaneous requests from nodes 2 and 5, held: 2, 5, 2.
        txn(16'h0024, 16'h0024, 2, M_ACK);
        txn(16'h0024, 16'h0024, 5, M_ACK);
        txn(16'h0024, 16'h0024, 2, M_ACK);

        // Single request from node 3; other requests mid-transfer are ignored.
        txn(16'h0008, 16'hFFF7, 3, M_ACK);

        // Node 15 wraps the pointer to 0, so node 0 beats node 15.
        txn(16'h8000, 16'h8000, 15, M_ACK);
        txn(16'h8001, 16'h8001, 0, M_ACK);

        // Missing start bit on node 7.
        txn(16'h0080, 16'h0080, 7, M_NOSTRT);

        // Full packet, then no ack, on node 4.
        txn(16'h0010, 16'h0010, 4, M_NOACK);

        // Reset at bit 40 of a node-1 transfer, then a normal node-1 transfer.
        txn(16'h0002, 16'h0002, 1, M_RESET);
        txn(16'h0002, 16'h0002, 1, M_ACK);

        ifc.req = '0;
        repeat (5) @(negedge clock);
        chk("sb_empty", sb.size(), 0);
        chk("final_busy", int'(ifc.busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Upstream controller for the shared single-wire node bus.
- Arbitrates transmit requests from up to 16 nodes and drives the one-hot `mod` vector that selects the single sender.
- Monitors the bus to track each transaction (80-bit packet, ack) and releases the bus only when the transaction completes or times out.
- Guarantees at most one sender at a time, with round-robin fairness.

Parameters:
- NODES, 16, number of nodes and width of the req/mod vectors.
- PKT_BITS, 80, packet length in bus cycles, start bit included.
- ACK_BITS, 2, consecutive high cycles that constitute an ack.
- TIMEOUT, 255, maximum cycles allowed in GRANT or WAIT_ACK.

Ports:
- clock, input, 1, system clock; all logic on posedge.
- reset, input, 1, synchronous, active-high.
- req, input, NODES, per-node transmit request; level-sensitive.
- bus, input, 1, monitored copy of the shared bus (bus_show).
- mod, output, NODES, one-hot sender select, or all zero; registered.
- owner, output, 4, index of the current or last granted node.
- busy, output, 1, high while in any state other than IDLE.
- done, output, 1, one-cycle pulse on ack-completed release.
- timeout_err, output, 1, one-cycle pulse on timeout release.

Behaviour:
- Interface: one clock, `clock`; reset is synchronous and active-high, port `reset`.
- Reset values: mod=0, owner=0, busy=0, done=0, timeout_err=0, round-robin pointer ptr=0, state=IDLE, bit_cnt=0, ack_cnt=0, tmo_cnt=0.
- Reset mid-transaction: all outputs take reset values on the same edge; mod drops immediately.
- Bus sampling: "low" means bus==1'b0, "high" means bus==1'b1. X or Z counts as neither.
- Winner selection: first asserted req at index ptr, ptr+1, …, NODES-1, 0, …, ptr-1 (wraps modulo NODES).

States:
- IDLE:
  - If req==0: stay; mod=0.
  - Else on edge N: mod[w]=1 for winner w, owner=w, tmo_cnt=0, go GRANT. mod is visible after edge N (1-cycle grant latency).
- GRANT (waiting for start bit):
  - Bus low: this cycle is packet bit 0; bit_cnt=1, go RECV.
  - Otherwise tmo_cnt++. At tmo_cnt==TIMEOUT: pulse timeout_err, go RELEASE.
- RECV:
  - Each cycle bit_cnt++, bus value ignored.
  - When bit_cnt reaches PKT_BITS (bits 0..79 consumed): ack_cnt=0, tmo_cnt=0, go WAIT_ACK.
- WAIT_ACK:
  - Bus high: ack_cnt++; any other value: ack_cnt=0. The sender's single low turnaround cycle therefore does not count.
  - When ack_cnt reaches ACK_BITS: pulse done, go RELEASE.
  - tmo_cnt++ every cycle; at TIMEOUT: pulse timeout_err, go RELEASE.
- RELEASE:
  - mod=0, ptr=(owner+1) mod NODES, go IDLE.
  - This guarantees at least one cycle with mod==0 between grants, so consecutive senders never overlap.

Other rules:
- mod is held constant from grant until RELEASE. req changes of the owner or of others during GRANT, RECV or WAIT_ACK are ignored.
- done and timeout_err are mutually exclusive and each lasts exactly one cycle.
- Minimum transaction, grant to IDLE: 1 (grant) + 0..TIMEOUT (start wait) + 80 + 1 (turnaround) + 2 (ack) + 1 (release) cycles.
- Counter widths: bit_cnt 7 bits, ack_cnt 2 bits, tmo_cnt 8 bits (sized for the defaults). tmo_cnt saturates; it does not wrap.
- busy=1 in GRANT, RECV, WAIT_ACK and RELEASE.

Test Plan:
1. **Single request.** req=16'h0008; bench drives start 0, 79 packet bits, one 0, then 1,1.
   - mod=16'h0008 one cycle after the req edge; owner=3.
   - done pulses on the second ack high; mod=0 the next cycle; ptr=4.
2. **Simultaneous requests, round robin.** req=16'h0024 held, ptr=0.
   - First grant mod=16'h0004 (node 2), after completion mod=16'h0020 (node 5), then node 2 again.
   - At least one mod==0 cycle between grants.
3. **Pointer wrap-around.** After node 15 completes, ptr=0; with req=16'h8001, node 0 wins next.
4. **Missing ack.** Full 80-bit packet, then bus held 0.
   - timeout_err pulses exactly TIMEOUT cycles after entering WAIT_ACK; done stays 0; mod clears.
5. **Missing start bit.** Grant to node 7 while bus held 1.
   - timeout_err after 255 cycles in GRANT; ptr=8.
6. **Reset mid-packet.** Assert reset at bit 40 of a node-1 transfer.
   - mod=0, busy=0, ptr=0 on that edge.
   - A fresh req=16'h0002 is granted normally afterwards.
